// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM/datapath
// encodings and the placement of remainder/quotient in a divide result.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_MUL     = 4'd2;
  localparam logic [3:0] ALU_DIV     = 4'd3;
  localparam logic [3:0] ALU_AND     = 4'd4;
  localparam logic [3:0] ALU_OR      = 4'd5;
  localparam logic [3:0] ALU_NAND    = 4'd6;
  localparam logic [3:0] ALU_NOR     = 4'd7;
  localparam logic [3:0] ALU_XOR     = 4'd8;
  localparam logic [3:0] ALU_XNOR    = 4'd9;
  localparam logic [3:0] ALU_EQ      = 4'd10;
  localparam logic [3:0] ALU_GT      = 4'd11;
  localparam logic [3:0] ALU_LT      = 4'd12;
  localparam logic [3:0] ALU_SHR     = 4'd13;
  localparam logic [3:0] ALU_SHL     = 4'd14;
  localparam logic [3:0] ALU_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  // Divide result = {remainder, quotient}, expressed as DATA_W-wide slots.
  localparam int unsigned DIV_QUOT_SLOT = 0;
  localparam int unsigned DIV_REM_SLOT  = 1;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one
// 2*DATA_W+1 working register; one step per clock, DATA_W steps per op.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  md_mode_e              mode,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result
);

  localparam int OUT_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int WR_W  = 2 * DATA_W + 1;

  logic               r_run;
  logic [CNT_W-1:0]   r_cnt;
  md_mode_e           r_mode;
  logic [WR_W-1:0]    r_w;
  logic [DATA_W-1:0]  r_m;

  logic [DATA_W:0]    w_sum;
  logic [DATA_W+1:0]  w_diff;
  logic [WR_W-1:0]    w_sh;
  logic [WR_W-1:0]    w_step;

  always_comb begin
    w_sum  = {1'b0, r_w[OUT_W-1:DATA_W]} + (r_w[0] ? {1'b0, r_m} : '0);
    w_sh   = {r_w[OUT_W-1:0], 1'b0};
    w_diff = {1'b0, w_sh[WR_W-1:DATA_W]} - {2'b00, r_m};
    if (r_mode == MD_MUL)
      w_step = {1'b0, w_sum, r_w[DATA_W-1:1]};
    else if (!w_diff[DATA_W+1])
      w_step = {w_diff[DATA_W:0], w_sh[DATA_W-1:1], 1'b1};
    else
      w_step = w_sh;
  end

  // The last step is handed out combinationally so the result registers at
  // the same edge that closes the DATA_W-th iteration.
  assign done   = r_run && (r_cnt == CNT_W'(DATA_W - 1));
  assign result = w_step[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_mode <= MD_MUL;
      r_w    <= '0;
      r_m    <= '0;
    end else if (start) begin
      r_run  <= 1'b1;
      r_cnt  <= '0;
      r_mode <= mode;
      if (mode == MD_MUL) begin
        r_w <= {{(DATA_W + 1){1'b0}}, b};
        r_m <= a;
      end else begin
        r_w <= {{(DATA_W + 1){1'b0}}, a};
        r_m <= b;
      end
    end else if (r_run) begin
      r_w <= w_step;
      if (done) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: start/busy/valid handshake, single-cycle ops computed at
// accept, MUL/DIV delegated to the iterative seq_muldiv datapath.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FUN_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     operand_a,
  input  logic [DATA_W-1:0]     operand_b,
  input  logic [FUN_W-1:0]      alu_fun,
  input  logic                  enable,
  output logic                  busy,
  output logic [2*DATA_W-1:0]   alu_out,
  output logic                  out_valid,
  output logic                  err
);

  localparam int OUT_W = 2 * DATA_W;
  localparam int SH_W  = $clog2(DATA_W);

  state_e             r_state, w_state_nxt;
  logic               w_accept, w_start, w_md_done;
  md_mode_e           w_mode;
  logic [OUT_W-1:0]   w_sc_res, w_md_res;
  logic [DATA_W-1:0]  w_n;
  logic               w_sc_err;

  assign busy     = (r_state != S_IDLE);
  assign w_accept = enable && !busy;
  assign w_mode   = (alu_fun == ALU_DIV) ? MD_DIV : MD_MUL;
  assign w_start  = w_accept && ((alu_fun == ALU_MUL) ||
                                 ((alu_fun == ALU_DIV) && (operand_b != '0)));

  seq_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .mode   (w_mode),
    .a      (operand_a),
    .b      (operand_b),
    .done   (w_md_done),
    .result (w_md_res)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = (w_mode == MD_DIV) ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (w_md_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_n      = '0;
    w_sc_res = '0;
    w_sc_err = 1'b0;
    case (alu_fun)
      ALU_ADD:  w_sc_res = OUT_W'(operand_a) + OUT_W'(operand_b);
      ALU_SUB:  w_sc_res = OUT_W'(operand_a) - OUT_W'(operand_b);
      ALU_DIV: begin
        // Only reaches the output path for a zero divisor.
        w_sc_res[DIV_QUOT_SLOT*DATA_W +: DATA_W] = '1;
        w_sc_res[DIV_REM_SLOT*DATA_W +: DATA_W]  = operand_a;
        w_sc_err = 1'b1;
      end
      ALU_AND:  begin w_n = operand_a & operand_b;    w_sc_res = {{DATA_W{1'b0}}, w_n}; end
      ALU_OR:   begin w_n = operand_a | operand_b;    w_sc_res = {{DATA_W{1'b0}}, w_n}; end
      ALU_NAND: begin w_n = ~(operand_a & operand_b); w_sc_res = {{DATA_W{1'b0}}, w_n}; end
      ALU_NOR:  begin w_n = ~(operand_a | operand_b); w_sc_res = {{DATA_W{1'b0}}, w_n}; end
      ALU_XOR:  begin w_n = operand_a ^ operand_b;    w_sc_res = {{DATA_W{1'b0}}, w_n}; end
      ALU_XNOR: begin w_n = ~(operand_a ^ operand_b); w_sc_res = {{DATA_W{1'b0}}, w_n}; end
      ALU_EQ:   w_sc_res = OUT_W'(operand_a == operand_b);
      ALU_GT:   w_sc_res = OUT_W'(operand_a > operand_b);
      ALU_LT:   w_sc_res = OUT_W'(operand_a < operand_b);
      ALU_SHR:  begin w_n = operand_a >> operand_b[SH_W-1:0]; w_sc_res = {{DATA_W{1'b0}}, w_n}; end
      ALU_SHL:  begin w_n = operand_a << operand_b[SH_W-1:0]; w_sc_res = {{DATA_W{1'b0}}, w_n}; end
      default:  begin w_sc_res = '0; w_sc_err = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      alu_out   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      out_valid <= 1'b0;
      if (w_accept && !w_start && (alu_fun != ALU_MUL)) begin
        alu_out   <= w_sc_res;
        out_valid <= 1'b1;
        err       <= w_sc_err;
      end else if (busy && w_md_done) begin
        alu_out   <= w_md_res;
        out_valid <= 1'b1;
        err       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at DATA_W=8.
module tb_seq_alu;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] operand_a = '0;
  logic [DW-1:0] operand_b = '0;
  logic [3:0]    alu_fun = '0;
  logic          enable = 1'b0;
  logic          busy;
  logic [2*DW-1:0] alu_out;
  logic          out_valid;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.DATA_W(DW), .FUN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .alu_fun   (alu_fun),
    .enable    (enable),
    .busy      (busy),
    .alu_out   (alu_out),
    .out_valid (out_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request so that it is accepted at the next rising edge,
  // then return #1 after that edge with enable dropped.
  task automatic issue(input logic [3:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    alu_fun = f; operand_a = a; operand_b = b; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] f, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [15:0] exp, input logic exp_err);
    issue(f, a, b);
    chk({tag, "_out"},   32'(alu_out),   32'(exp));
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_err"},   32'(err),       32'(exp_err));
    chk({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  // Called #1 after the accept edge of a MUL/DIV.
  task automatic md_wait(input string tag, input logic [15:0] exp);
    int bad = 0;
    chk({tag, "_busy_k"}, 32'(busy), 32'd1);
    repeat (DW - 1) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
    end
    chk({tag, "_busy_window"}, 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_out"}, 32'(alu_out), 32'(exp));
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int bad;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",   32'(alu_out),   32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_err",   32'(err),       32'd0);
    @(negedge clk); rst = 1'b1;

    // Single-cycle ops
    single("add_carry", 4'd0,  8'hFF, 8'h01, 16'h0100, 1'b0);
    @(posedge clk); #1;
    chk("add_pulse_end", 32'(out_valid), 32'd0);
    chk("add_hold",      32'(alu_out),   32'h0100);
    single("sub_borrow", 4'd1,  8'h01, 8'h02, 16'hFFFF, 1'b0);
    single("and",        4'd4,  8'hF0, 8'h3C, 16'h0030, 1'b0);
    single("nand",       4'd6,  8'hF0, 8'h3C, 16'h00CF, 1'b0);
    single("nor",        4'd7,  8'hF0, 8'h0C, 16'h0003, 1'b0);
    single("xnor",       4'd9,  8'hA5, 8'h0F, 16'h0055, 1'b0);
    single("eq",         4'd10, 8'h5A, 8'h5A, 16'h0001, 1'b0);
    single("gt_false",   4'd11, 8'h10, 8'h20, 16'h0000, 1'b0);
    single("lt",         4'd12, 8'h10, 8'h20, 16'h0001, 1'b0);
    single("shr",        4'd13, 8'h80, 8'h03, 16'h0010, 1'b0);
    single("shl_trunc",  4'd14, 8'h81, 8'h0A, 16'h0004, 1'b0);

    // MUL
    issue(4'd2, 8'hFF, 8'hFF);
    chk("mul_ff_valid_k", 32'(out_valid), 32'd0);
    md_wait("mul_ff", 16'hFE01);
    issue(4'd2, 8'h00, 8'h37);
    md_wait("mul_zero", 16'h0000);

    // DIV: 200 = 28*7 + 4, 5 = 0*9 + 5
    issue(4'd3, 8'd200, 8'd7);
    md_wait("div_200_7", 16'h041C);
    issue(4'd3, 8'd5, 8'd9);
    md_wait("div_5_9", 16'h0500);

    // Divide by zero and illegal code
    single("div_zero", 4'd3,  8'h55, 8'h00, 16'h55FF, 1'b1);
    @(posedge clk); #1;
    chk("div_zero_no_busy", 32'(busy), 32'd0);
    chk("err_hold",         32'(err),  32'd1);
    single("illegal",  4'd15, 8'h12, 8'h34, 16'h0000, 1'b1);

    // Requests during busy are ignored; one in the out_valid cycle is taken.
    @(negedge clk);
    alu_fun = 4'd2; operand_a = 8'h03; operand_b = 8'h05; enable = 1'b1;
    @(posedge clk); #1;
    alu_fun = 4'd0; operand_a = 8'h01; operand_b = 8'h01;
    md_wait("mul_busy_ign", 16'h000F);
    @(posedge clk); #1;
    enable = 1'b0;
    chk("b2b_add_valid", 32'(out_valid), 32'd1);
    chk("b2b_add_out",   32'(alu_out),   32'h0002);
    chk("b2b_add_busy",  32'(busy),      32'd0);

    // Reset during DIV aborts it
    issue(4'd3, 8'd200, 8'd7);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_out",   32'(alu_out),   32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_err",   32'(err),       32'd0);
    @(negedge clk); rst = 1'b1;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("abort_no_result", 32'(bad), 32'd0);
    issue(4'd2, 8'h10, 8'h10);
    md_wait("mul_after_rst", 16'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
